// File: rtl/rob_recovery_ctrl.sv
// -----------------------------------------------------------------------------
// rob_recovery_ctrl
//
// Sequences branch-mispredict recovery after the ROB flush. On branch_haz the
// squashed physical tags and the correct target PC are captured. Dispatch is
// stalled while the nonzero tags are handed back to the free list, up to N_WAY
// per cycle, in ascending ROB-index order. A one-cycle fetch redirect then
// closes the sequence.
//
// Handshake: a return lane transfers on a cycle where fl_ret_valid[k]=1 and
// fl_ready=1. While fl_ready=0 the lane outputs hold steady and no state
// changes. fl_ret_valid never depends on fl_ready.
//
// Ports:
//   clock, reset_n   rising-edge clock, asynchronous active-low reset
//   branch_haz       ROB flush pulse; br_target_pc / free_list_haz valid with it
//   fl_ready         free list accepts the presented lanes this cycle
//   fl_ret_valid/tag per-lane tag return (unused lanes are valid=0, tag=0)
//   stall_dispatch   branch_haz | busy; combinational so the flush cycle stalls
//   redirect_valid/pc one-cycle fetch redirect
//   busy             FSM is not IDLE (state observation point)
//   recov_err        sticky: branch_haz arrived while busy
// -----------------------------------------------------------------------------
module rob_recovery_ctrl #(
    parameter int N_ROB    = 32,
    parameter int N_WAY    = 2,
    parameter int CDB_BITS = 6,
    parameter int XLEN     = 32
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      branch_haz,
    input  logic [XLEN-1:0]           br_target_pc,
    input  logic [N_ROB*CDB_BITS-1:0] free_list_haz,
    input  logic                      fl_ready,
    output logic [N_WAY-1:0]          fl_ret_valid,
    output logic [N_WAY*CDB_BITS-1:0] fl_ret_tag,
    output logic                      stall_dispatch,
    output logic                      redirect_valid,
    output logic [XLEN-1:0]           redirect_pc,
    output logic                      busy,
    output logic                      recov_err
);

    localparam int IDX_W = (N_ROB > 1) ? $clog2(N_ROB) : 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DRAIN    = 2'd1,
        S_REDIRECT = 2'd2
    } state_e;

    state_e              state_q;
    logic [N_ROB-1:0]    pend_q;
    logic [CDB_BITS-1:0] tags_q [N_ROB];
    logic [XLEN-1:0]     pc_q;
    logic                recov_err_q;

    // Pending mask for a fresh capture: one bit per nonzero incoming tag.
    logic [N_ROB-1:0] cap_pend;

    always_comb begin
        cap_pend = '0;
        for (int i = 0; i < N_ROB; i++) begin
            cap_pend[i] = |free_list_haz[i*CDB_BITS +: CDB_BITS];
        end
    end

    // Lane k picks the lowest pending bit not already taken by lanes 0..k-1.
    // The descending scan leaves the lowest set index in lane_idx.
    logic [N_ROB-1:0] avail;
    logic [N_ROB-1:0] sel_mask;
    logic [N_WAY-1:0] lane_vld;
    logic [IDX_W-1:0] lane_idx [N_WAY];

    always_comb begin
        avail    = pend_q;
        sel_mask = '0;
        lane_vld = '0;
        for (int k = 0; k < N_WAY; k++) begin
            lane_idx[k] = '0;
            for (int i = N_ROB - 1; i >= 0; i--) begin
                if (avail[i]) begin
                    lane_idx[k] = IDX_W'(i);
                end
            end
            lane_vld[k] = |avail;
            if (lane_vld[k]) begin
                avail[lane_idx[k]]    = 1'b0;
                sel_mask[lane_idx[k]] = 1'b1;
            end
        end
    end

    // Mask left after this cycle's lanes are accepted.
    logic [N_ROB-1:0] pend_after;
    assign pend_after = pend_q & ~sel_mask;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            pend_q      <= '0;
            pc_q        <= '0;
            recov_err_q <= 1'b0;
            for (int i = 0; i < N_ROB; i++) begin
                tags_q[i] <= '0;
            end
        end else begin
            // A second flush while recovering cannot be honoured; flag it.
            if (branch_haz && (state_q != S_IDLE)) begin
                recov_err_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (branch_haz) begin
                        for (int i = 0; i < N_ROB; i++) begin
                            tags_q[i] <= free_list_haz[i*CDB_BITS +: CDB_BITS];
                        end
                        pend_q  <= cap_pend;
                        pc_q    <= br_target_pc;
                        state_q <= (|cap_pend) ? S_DRAIN : S_REDIRECT;
                    end
                end
                S_DRAIN: begin
                    if (fl_ready) begin
                        pend_q <= pend_after;
                        if (pend_after == '0) begin
                            state_q <= S_REDIRECT;
                        end
                    end
                end
                S_REDIRECT: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Return lanes decode purely from registered state.
    always_comb begin
        fl_ret_valid = '0;
        fl_ret_tag   = '0;
        if (state_q == S_DRAIN) begin
            for (int k = 0; k < N_WAY; k++) begin
                if (lane_vld[k]) begin
                    fl_ret_valid[k]                         = 1'b1;
                    fl_ret_tag[k*CDB_BITS +: CDB_BITS]      = tags_q[lane_idx[k]];
                end
            end
        end
    end

    assign busy           = (state_q != S_IDLE);
    assign stall_dispatch = branch_haz | busy;
    assign redirect_valid = (state_q == S_REDIRECT);
    assign redirect_pc    = (state_q == S_REDIRECT) ? pc_q : '0;
    assign recov_err      = recov_err_q;

endmodule

// File: tb/tb_rob_recovery_ctrl.sv
// Bench for rob_recovery_ctrl: directed scenarios plus randomized flushes
// checked against a queue-based reference model of the return order.
module tb_rob_recovery_ctrl;

  localparam int N_ROB    = 32;
  localparam int N_WAY    = 2;
  localparam int CDB_BITS = 6;
  localparam int XLEN     = 32;
  localparam int FLW      = N_ROB * CDB_BITS;
  localparam int LTW      = N_WAY * CDB_BITS;

  // ---------------- clock / reset / DUT ----------------
  logic                clock = 1'b0;
  logic                reset_n = 1'b1;
  logic                branch_haz = 1'b0;
  logic [XLEN-1:0]     br_target_pc = '0;
  logic [FLW-1:0]      free_list_haz = '0;
  logic                fl_ready = 1'b0;
  logic [N_WAY-1:0]    fl_ret_valid;
  logic [LTW-1:0]      fl_ret_tag;
  logic                stall_dispatch;
  logic                redirect_valid;
  logic [XLEN-1:0]     redirect_pc;
  logic                busy;
  logic                recov_err;

  always #5 clock = ~clock;

  rob_recovery_ctrl #(
    .N_ROB(N_ROB), .N_WAY(N_WAY), .CDB_BITS(CDB_BITS), .XLEN(XLEN)
  ) dut (
    .clock(clock), .reset_n(reset_n), .branch_haz(branch_haz),
    .br_target_pc(br_target_pc), .free_list_haz(free_list_haz),
    .fl_ready(fl_ready), .fl_ret_valid(fl_ret_valid), .fl_ret_tag(fl_ret_tag),
    .stall_dispatch(stall_dispatch), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .busy(busy), .recov_err(recov_err)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [CDB_BITS-1:0] exp_q[$];
  logic [CDB_BITS-1:0] got_q[$];

  // ---------------- driver helpers ----------------
  function automatic logic [FLW-1:0] put_tag(input logic [FLW-1:0] v, input int idx,
                                             input logic [CDB_BITS-1:0] t);
    logic [FLW-1:0] r;
    r = v;
    r[idx*CDB_BITS +: CDB_BITS] = t;
    return r;
  endfunction

  function automatic logic [FLW-1:0] basic_tags();
    logic [FLW-1:0] v;
    v = '0;
    v = put_tag(v, 1, 6'd7);
    v = put_tag(v, 4, 6'd9);
    v = put_tag(v, 5, 6'd12);
    return v;
  endfunction

  // Drives the flush pulse at a falling edge (cycle 0); caller releases it.
  task automatic drive_flush(input logic [FLW-1:0] flh, input logic [XLEN-1:0] pc,
                             input logic rdy);
    @(negedge clock);
    branch_haz    = 1'b1;
    free_list_haz = flh;
    br_target_pc  = pc;
    fl_ready      = rdy;
  endtask

  task automatic end_pulse();
    @(negedge clock);
    branch_haz    = 1'b0;
    free_list_haz = '0;
    br_target_pc  = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    branch_haz = 1'b0; fl_ready = 1'b0; free_list_haz = '0; br_target_pc = '0;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({fl_ret_valid, fl_ret_tag, stall_dispatch, redirect_valid, redirect_pc, busy, recov_err} !== '0)
      $display("FAIL reset_async: got valid=%b tag=%h stall=%b rv=%b pc=%h busy=%b err=%b, want all 0",
               fl_ret_valid, fl_ret_tag, stall_dispatch, redirect_valid, redirect_pc, busy, recov_err);
    else n_pass++;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({fl_ret_valid, fl_ret_tag, stall_dispatch, redirect_valid, redirect_pc, busy, recov_err} !== '0)
      $display("FAIL reset_release: got valid=%b tag=%h stall=%b rv=%b pc=%h busy=%b err=%b, want all 0",
               fl_ret_valid, fl_ret_tag, stall_dispatch, redirect_valid, redirect_pc, busy, recov_err);
    else n_pass++;
  endtask

  task automatic test_basic_drain();
    drive_flush(basic_tags(), 32'h400, 1'b1);
    #1;
    n_checks++;
    if ({stall_dispatch, busy, fl_ret_valid} !== {1'b1, 1'b0, 2'b00})
      $display("FAIL basic_cyc0: stall=%b busy=%b valid=%b, want 1 0 00", stall_dispatch, busy, fl_ret_valid);
    else n_pass++;
    end_pulse();  // cycle 1
    n_checks++;
    if ({fl_ret_valid, fl_ret_tag, redirect_valid, stall_dispatch} !== {2'b11, 6'd9, 6'd7, 1'b0, 1'b1})
      $display("FAIL basic_cyc1: valid=%b tag=%h rv=%b stall=%b, want 11 {9,7} 0 1",
               fl_ret_valid, fl_ret_tag, redirect_valid, stall_dispatch);
    else n_pass++;
    @(negedge clock);  // cycle 2
    n_checks++;
    if ({fl_ret_valid, fl_ret_tag, redirect_valid} !== {2'b01, 6'd0, 6'd12, 1'b0})
      $display("FAIL basic_cyc2: valid=%b tag=%h rv=%b, want 01 {0,12} 0", fl_ret_valid, fl_ret_tag, redirect_valid);
    else n_pass++;
    @(negedge clock);  // cycle 3
    n_checks++;
    if ({redirect_valid, redirect_pc, fl_ret_valid, stall_dispatch} !== {1'b1, 32'h400, 2'b00, 1'b1})
      $display("FAIL basic_cyc3: rv=%b pc=%h valid=%b stall=%b, want 1 400 00 1",
               redirect_valid, redirect_pc, fl_ret_valid, stall_dispatch);
    else n_pass++;
    @(negedge clock);  // cycle 4
    n_checks++;
    if ({redirect_valid, stall_dispatch, busy} !== 3'b000)
      $display("FAIL basic_cyc4: rv=%b stall=%b busy=%b, want 000", redirect_valid, stall_dispatch, busy);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [N_WAY+LTW-1:0] exp_l;
    got_q.delete();
    drive_flush(basic_tags(), 32'h400, 1'b0);
    end_pulse();  // cycle 1
    for (int c = 1; c <= 4; c++) begin
      exp_l = (c <= 3) ? {2'b11, 6'd9, 6'd7} : {2'b01, 6'd0, 6'd12};
      n_checks++;
      if ({fl_ret_valid, fl_ret_tag} !== exp_l)
        $display("FAIL bp_cyc%0d: valid=%b tag=%h, want %h", c, fl_ret_valid, fl_ret_tag, exp_l);
      else n_pass++;
      fl_ready = (c >= 3);
      for (int k = 0; k < N_WAY; k++)
        if (fl_ready && fl_ret_valid[k]) got_q.push_back(fl_ret_tag[k*CDB_BITS +: CDB_BITS]);
      @(negedge clock);
    end
    n_checks++;  // cycle 5
    if ({redirect_valid, redirect_pc} !== {1'b1, 32'h400})
      $display("FAIL bp_redirect: rv=%b pc=%h, want 1 400", redirect_valid, redirect_pc);
    else n_pass++;
    n_checks++;
    if (got_q.size() != 3 || got_q[0] !== 6'd7 || got_q[1] !== 6'd9 || got_q[2] !== 6'd12)
      $display("FAIL bp_returned: got %p, want '{7,9,12}", got_q);
    else n_pass++;
    @(negedge clock);
    n_checks++;
    if ({busy, stall_dispatch} !== 2'b00)
      $display("FAIL bp_idle: busy=%b stall=%b, want 00", busy, stall_dispatch);
    else n_pass++;
  endtask

  task automatic test_empty_flush();
    drive_flush('0, 32'h80, 1'b1);
    #1;
    n_checks++;
    if (stall_dispatch !== 1'b1)
      $display("FAIL empty_cyc0: stall=%b, want 1", stall_dispatch);
    else n_pass++;
    end_pulse();  // cycle 1
    n_checks++;
    if ({redirect_valid, redirect_pc, fl_ret_valid, stall_dispatch} !== {1'b1, 32'h80, 2'b00, 1'b1})
      $display("FAIL empty_cyc1: rv=%b pc=%h valid=%b stall=%b, want 1 80 00 1",
               redirect_valid, redirect_pc, fl_ret_valid, stall_dispatch);
    else n_pass++;
    @(negedge clock);
    n_checks++;
    if ({redirect_valid, fl_ret_valid, stall_dispatch, busy} !== 5'b0)
      $display("FAIL empty_cyc2: rv=%b valid=%b stall=%b busy=%b, want 0", redirect_valid, fl_ret_valid,
               stall_dispatch, busy);
    else n_pass++;
  endtask

  task automatic test_spurious();
    logic [FLW-1:0] other;
    other = put_tag('0, 0, 6'd33);
    other = put_tag(other, 2, 6'd44);
    drive_flush(basic_tags(), 32'h400, 1'b0);
    end_pulse();  // cycle 1: drain running, inject a second flush
    branch_haz = 1'b1; free_list_haz = other; br_target_pc = 32'h999;
    @(negedge clock);  // cycle 2
    branch_haz = 1'b0; free_list_haz = '0; br_target_pc = '0;
    n_checks++;
    if ({fl_ret_valid, fl_ret_tag, recov_err, busy} !== {2'b11, 6'd9, 6'd7, 1'b1, 1'b1})
      $display("FAIL spur_hold: valid=%b tag=%h err=%b busy=%b, want 11 {9,7} 1 1",
               fl_ret_valid, fl_ret_tag, recov_err, busy);
    else n_pass++;
    fl_ready = 1'b1;
    @(negedge clock);  // cycle 3
    n_checks++;
    if ({fl_ret_valid, fl_ret_tag} !== {2'b01, 6'd0, 6'd12})
      $display("FAIL spur_second: valid=%b tag=%h, want 01 {0,12}", fl_ret_valid, fl_ret_tag);
    else n_pass++;
    @(negedge clock);  // cycle 4
    n_checks++;
    if ({redirect_valid, redirect_pc} !== {1'b1, 32'h400})
      $display("FAIL spur_redirect: rv=%b pc=%h, want 1 400", redirect_valid, redirect_pc);
    else n_pass++;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({recov_err, busy} !== 2'b10)
      $display("FAIL spur_sticky: err=%b busy=%b, want 1 0", recov_err, busy);
    else n_pass++;
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    n_checks++;
    if (recov_err !== 1'b0)
      $display("FAIL spur_err_clear: err=%b, want 0", recov_err);
    else n_pass++;
  endtask

  task automatic test_reset_mid_drain();
    drive_flush(basic_tags(), 32'h400, 1'b0);
    end_pulse();
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({fl_ret_valid, fl_ret_tag, busy, stall_dispatch, redirect_valid} !== '0)
      $display("FAIL mid_reset: valid=%b tag=%h busy=%b stall=%b rv=%b, want all 0",
               fl_ret_valid, fl_ret_tag, busy, stall_dispatch, redirect_valid);
    else n_pass++;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    n_checks++;
    if ({fl_ret_valid, busy} !== '0)
      $display("FAIL mid_reset_after: valid=%b busy=%b, want 0", fl_ret_valid, busy);
    else n_pass++;
  endtask

  // Reference model: nonzero tags in ascending index order, N_WAY consumed per
  // accepted cycle, redirect once the queue is empty.
  task automatic test_model_flush(input string name, input logic [FLW-1:0] flh,
                                  input logic [XLEN-1:0] pc, input int ready_pct);
    logic [N_WAY-1:0] ev;
    logic [LTW-1:0]   et;
    int n_exp, n_got, drain_cyc, take;
    bit done;
    exp_q.delete();
    for (int i = 0; i < N_ROB; i++)
      if (flh[i*CDB_BITS +: CDB_BITS] != '0) exp_q.push_back(flh[i*CDB_BITS +: CDB_BITS]);
    n_exp = exp_q.size(); n_got = 0; drain_cyc = 0; done = 0;
    drive_flush(flh, pc, 1'b0);
    #1;
    n_checks++;
    if (stall_dispatch !== 1'b1) $display("FAIL %s_cyc0: stall=%b, want 1", name, stall_dispatch);
    else n_pass++;
    end_pulse();
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      if (exp_q.size() > 0) begin
        ev = '0; et = '0;
        take = (exp_q.size() < N_WAY) ? exp_q.size() : N_WAY;
        for (int k = 0; k < take; k++) begin
          ev[k] = 1'b1; et[k*CDB_BITS +: CDB_BITS] = exp_q[k];
        end
        n_checks++;
        if ({fl_ret_valid, fl_ret_tag, redirect_valid, busy, stall_dispatch} !== {ev, et, 1'b0, 1'b1, 1'b1})
          $display("FAIL %s_lanes: valid=%b tag=%h rv=%b busy=%b stall=%b, want valid=%b tag=%h",
                   name, fl_ret_valid, fl_ret_tag, redirect_valid, busy, stall_dispatch, ev, et);
        else n_pass++;
        fl_ready = ($urandom_range(99) < ready_pct);
        if (fl_ready) begin
          for (int k = 0; k < take; k++) void'(exp_q.pop_front());
          n_got += take;
        end
        drain_cyc++;
        @(negedge clock);
      end else begin
        n_checks++;
        if ({redirect_valid, redirect_pc, fl_ret_valid} !== {1'b1, pc, 2'b00})
          $display("FAIL %s_redirect: rv=%b pc=%h valid=%b, want 1 %h 00",
                   name, redirect_valid, redirect_pc, fl_ret_valid, pc);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if ({busy, stall_dispatch, redirect_valid} !== 3'b000)
          $display("FAIL %s_idle: busy=%b stall=%b rv=%b, want 000", name, busy, stall_dispatch, redirect_valid);
        else n_pass++;
        done = 1;
      end
    end
    n_checks++;
    if (!done || n_got != n_exp)
      $display("FAIL %s_complete: done=%0d returned=%0d, want done=1 returned=%0d", name, done, n_got, n_exp);
    else n_pass++;
    if (ready_pct >= 100) begin
      n_checks++;
      if (drain_cyc != (n_exp + N_WAY - 1) / N_WAY)
        $display("FAIL %s_latency: drain cycles=%0d, want %0d", name, drain_cyc, (n_exp + N_WAY - 1) / N_WAY);
      else n_pass++;
    end
    fl_ready = 1'b0;
  endtask

  task automatic test_full_rob();
    logic [FLW-1:0] v;
    v = '0;
    for (int i = 0; i < N_ROB; i++) v = put_tag(v, i, CDB_BITS'(i + 1));
    test_model_flush("full", v, 32'h1234_5678, 100);
  endtask

  task automatic test_random();
    logic [FLW-1:0] v;
    for (int n = 0; n < 25; n++) begin
      v = '0;
      for (int i = 0; i < N_ROB; i++)
        if ($urandom_range(1) == 1) v = put_tag(v, i, CDB_BITS'($urandom_range(63, 1)));
      test_model_flush("rand", v, $urandom, (n % 3 == 0) ? 100 : 60);
    end
  endtask

  initial begin
    test_reset();
    test_basic_drain();
    test_backpressure();
    test_empty_flush();
    test_spurious();
    test_reset_mid_drain();
    test_full_rob();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
